// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide main-memory port between an I-cache (fills only) and a
// D-cache (fills and writebacks). One transaction is in flight at a time:
//   IDLE -> pick a requester and latch its request
//   BUSY -> hold the memory request stable until mem_ready
//   RESP -> pulse the winner's ready for one cycle
// The D side normally wins. After two D grants in a row, a waiting I request
// is served next so the instruction side cannot be starved.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ic_req/ic_addr        I-cache fill request (held until ic_ready)
//   ic_ready/ic_rdata     one-cycle completion pulse and fill line
//   dc_req/dc_we/dc_addr  D-cache request, 1 = writeback, 0 = fill
//   dc_wdata              D-cache writeback line
//   dc_ready/dc_rdata     one-cycle completion pulse and fill line
//   mem_req/mem_we        memory request (held until mem_ready) and direction
//   mem_addr/mem_wdata    line-aligned address and write line
//   mem_rdata/mem_ready   memory read line and completion
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ic_req,
  input  logic [ADDR_BITS-1:0] ic_addr,
  output logic                 ic_ready,
  output logic [LINE_BITS-1:0] ic_rdata,
  input  logic                 dc_req,
  input  logic                 dc_we,
  input  logic [ADDR_BITS-1:0] dc_addr,
  input  logic [LINE_BITS-1:0] dc_wdata,
  output logic                 dc_ready,
  output logic [LINE_BITS-1:0] dc_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wdata,
  input  logic [LINE_BITS-1:0] mem_rdata,
  input  logic                 mem_ready
);

  // Number of byte-offset bits inside one line; these are cleared on mem_addr.
  localparam int OFFS_BITS = $clog2(LINE_BITS / 8);
  localparam logic [ADDR_BITS-1:0] OFFS_MASK = ADDR_BITS'((64'd1 << OFFS_BITS) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 owner_dc_q, owner_dc_d;   // 1 = D-cache owns the transaction
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LINE_BITS-1:0] wdata_q, wdata_d;
  logic [LINE_BITS-1:0] ic_rdata_q, ic_rdata_d;
  logic [LINE_BITS-1:0] dc_rdata_q, dc_rdata_d;
  logic [1:0]           streak_q, streak_d;       // consecutive D grants, saturates at 2
  logic                 grant_dc_s;
  logic                 grant_ic_s;

  // Arbitration: D wins unless it has already taken two grants in a row while
  // the I side is waiting.
  always_comb begin
    grant_dc_s = 1'b0;
    grant_ic_s = 1'b0;
    if (dc_req && !(ic_req && (streak_q >= 2'd2))) begin
      grant_dc_s = 1'b1;
    end else if (ic_req) begin
      grant_ic_s = 1'b1;
    end else begin
      grant_dc_s = 1'b0;
      grant_ic_s = 1'b0;
    end
  end

  // Next-state logic. Requester inputs are only looked at in IDLE; in BUSY and
  // RESP everything comes from the latched registers.
  always_comb begin
    state_d    = state_q;
    owner_dc_d = owner_dc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    ic_rdata_d = ic_rdata_q;
    dc_rdata_d = dc_rdata_q;
    streak_d   = streak_q;
    case (state_q)
      IDLE: begin
        if (grant_dc_s) begin
          state_d    = BUSY;
          owner_dc_d = 1'b1;
          we_d       = dc_we;
          addr_d     = dc_addr;
          wdata_d    = dc_wdata;
          streak_d   = (streak_q >= 2'd2) ? 2'd2 : (streak_q + 2'd1);
        end else if (grant_ic_s) begin
          // The I side never writes, whatever dc_we happens to be.
          state_d    = BUSY;
          owner_dc_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = ic_addr;
          wdata_d    = {LINE_BITS{1'b0}};
          streak_d   = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = RESP;
          // Only reads return data; a writeback leaves both rdata registers alone.
          if (!we_q) begin
            if (owner_dc_q) begin
              dc_rdata_d = mem_rdata;
            end else begin
              ic_rdata_d = mem_rdata;
            end
          end else begin
            dc_rdata_d = dc_rdata_q;
          end
        end else begin
          state_d = BUSY;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched-request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      owner_dc_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= {ADDR_BITS{1'b0}};
      wdata_q    <= {LINE_BITS{1'b0}};
      ic_rdata_q <= {LINE_BITS{1'b0}};
      dc_rdata_q <= {LINE_BITS{1'b0}};
      streak_q   <= 2'd0;
    end else begin
      state_q    <= state_d;
      owner_dc_q <= owner_dc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      streak_q   <= streak_d;
    end
  end

  // Outputs are pure decodes of registered state, so they change only on clk.
  assign mem_req   = (state_q == BUSY);
  assign mem_we    = we_q & (state_q == BUSY);
  assign mem_addr  = addr_q & ~OFFS_MASK;
  assign mem_wdata = wdata_q;
  assign ic_ready  = (state_q == RESP) & ~owner_dc_q;
  assign dc_ready  = (state_q == RESP) &  owner_dc_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for mem_arbiter. Directed scenario tasks followed by a randomized run
// checked against a transaction-level model (grant rule + streak counter +
// per-requester expected rdata). Inputs change on the falling edge, outputs are
// checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;

  logic          clk;
  logic          rst;
  logic          ic_req;
  logic [AW-1:0] ic_addr;
  logic          ic_ready;
  logic [LW-1:0] ic_rdata;
  logic          dc_req;
  logic          dc_we;
  logic [AW-1:0] dc_addr;
  logic [LW-1:0] dc_wdata;
  logic          dc_ready;
  logic [LW-1:0] dc_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  mem_arbiter #(.ADDR_BITS(AW), .LINE_BITS(LW)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_ready(dc_ready), .dc_rdata(dc_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b1;
    ic_addr = 32'h0000_1234; dc_addr = 32'h0000_5678; dc_wdata = rand_line();
    mem_ready = 1'b1; mem_rdata = rand_line();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %0b exp 0", mem_req); end
      n_cmp++; if (ic_ready !== 1'b0 || dc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got ic=%0b dc=%0b exp 0", ic_ready, dc_ready); end
    end
    n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got %0b exp 0", mem_we); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr got %0h exp 0", mem_addr); end
    n_cmp++; if (ic_rdata !== {LW{1'b0}} || dc_rdata !== {LW{1'b0}}) begin n_fail++; $display("FAIL reset_rdata got ic=%0h dc=%0h exp 0", ic_rdata, dc_rdata); end
    rst = 1'b0; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
  endtask

  // I fill at 0x1004, memory answers after three stalled BUSY cycles; ic_addr is
  // scribbled mid-transaction and must not reach mem_addr.
  task automatic test_ic_fill();
    logic [LW-1:0] a5;
    a5 = {16{8'hA5}};
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h0000_1004; dc_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL ic_fill_mem_req cyc%0d got %0b exp 1", i, mem_req); end
      n_cmp++; if (mem_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL ic_fill_mem_addr cyc%0d got %0h exp 1000", i, mem_addr); end
      n_cmp++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL ic_fill_mem_we cyc%0d got %0b exp 0", i, mem_we); end
      n_cmp++; if (ic_ready !== 1'b0) begin n_fail++; $display("FAIL ic_fill_early_ready cyc%0d got %0b exp 0", i, ic_ready); end
      if (i == 1) ic_addr = 32'hDEAD_BEEC;
      mem_ready = (i == 4);
      mem_rdata = (i == 4) ? a5 : rand_line();
    end
    @(negedge clk);
    n_cmp++; if (ic_ready !== 1'b1 || dc_ready !== 1'b0) begin n_fail++; $display("FAIL ic_fill_ready got ic=%0b dc=%0b exp ic=1 dc=0", ic_ready, dc_ready); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL ic_fill_resp_mem_req got %0b exp 0", mem_req); end
    n_cmp++; if (ic_rdata !== a5) begin n_fail++; $display("FAIL ic_fill_rdata got %0h exp %0h", ic_rdata, a5); end
    ic_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (ic_ready !== 1'b0) begin n_fail++; $display("FAIL ic_fill_pulse_width got %0b exp 0", ic_ready); end
    n_cmp++; if (ic_rdata !== a5) begin n_fail++; $display("FAIL ic_fill_rdata_hold got %0h exp %0h", ic_rdata, a5); end
  endtask

  // A D fill to preload dc_rdata, then a minimum-latency writeback that must
  // leave dc_rdata untouched.
  task automatic test_dc_writeback();
    logic [LW-1:0] fill;
    fill = {16{8'h5A}};
    do_reset();
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0300;
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = fill;
    @(negedge clk);
    n_cmp++; if (dc_ready !== 1'b1 || dc_rdata !== fill) begin n_fail++; $display("FAIL dc_fill got rdy=%0b data=%0h exp rdy=1 data=%0h", dc_ready, dc_rdata, fill); end
    dc_req = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0200; dc_wdata = 128'h1234;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++; $display("FAIL dc_wb_req got req=%0b we=%0b exp 1 1", mem_req, mem_we); end
    n_cmp++; if (mem_wdata !== 128'h1234) begin n_fail++; $display("FAIL dc_wb_wdata got %0h exp 1234", mem_wdata); end
    n_cmp++; if (mem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL dc_wb_addr got %0h exp 200", mem_addr); end
    mem_ready = 1'b1; mem_rdata = {LW{1'b1}};
    @(negedge clk);
    n_cmp++; if (dc_ready !== 1'b1 || ic_ready !== 1'b0) begin n_fail++; $display("FAIL dc_wb_ready got dc=%0b ic=%0b exp dc=1 ic=0", dc_ready, ic_ready); end
    n_cmp++; if (dc_rdata !== fill) begin n_fail++; $display("FAIL dc_wb_rdata_kept got %0h exp %0h", dc_rdata, fill); end
    dc_req = 1'b0; dc_we = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (dc_ready !== 1'b0) begin n_fail++; $display("FAIL dc_wb_pulse_width got %0b exp 0", dc_ready); end
  endtask

  // Both requesters held high: grants must come out D D I D D I.
  task automatic test_back_to_back();
    string got;
    string exp_seq;
    int    grants;
    exp_seq = "DDIDDI";
    got     = "";
    grants  = 0;
    do_reset();
    ic_req = 1'b1; ic_addr = 32'h0000_1000;
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_2000;
    for (int c = 0; c < 40 && grants < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (ic_ready === 1'b1 && dc_ready === 1'b1) begin n_fail++; $display("FAIL b2b_both_ready got 1 1 exp at most one"); end
      if (mem_req === 1'b1) begin
        got = {got, (mem_addr == 32'h0000_2000) ? "D" : "I"};
        grants++;
        mem_ready = 1'b1; mem_rdata = rand_line();
      end else begin
        mem_ready = 1'b0;
      end
    end
    n_cmp++; if (got != exp_seq) begin n_fail++; $display("FAIL b2b_order got %s exp %s", got, exp_seq); end
    do_reset();
  endtask

  // mem_ready pulses with nothing in flight must be ignored.
  task automatic test_idle_ready();
    logic [LW-1:0] c3;
    c3 = {16{8'hC3}};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1; mem_rdata = rand_line();
      @(negedge clk);
      n_cmp++; if (mem_req !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_spurious got req=%0b ic=%0b dc=%0b exp 0 0 0", mem_req, ic_ready, dc_ready); end
    end
    ic_req = 1'b1; ic_addr = 32'h0000_0040;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || ic_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready_grant got req=%0b rdy=%0b exp 1 0", mem_req, ic_ready); end
    mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL idle_ready_still_busy got %0b exp 1", mem_req); end
    mem_ready = 1'b1; mem_rdata = c3;
    @(negedge clk);
    n_cmp++; if (ic_ready !== 1'b1 || ic_rdata !== c3) begin n_fail++; $display("FAIL idle_ready_done got rdy=%0b data=%0h exp 1 %0h", ic_ready, ic_rdata, c3); end
    ic_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Reset during the second BUSY cycle of a D fill abandons it cleanly.
  task automatic test_reset_busy();
    do_reset();
    dc_req = 1'b1; dc_we = 1'b0; dc_addr = 32'h0000_0400;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_first got %0b exp 1", mem_req); end
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_second got %0b exp 1", mem_req); end
    rst = 1'b1; mem_ready = 1'b1; mem_rdata = rand_line();
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0 || dc_ready !== 1'b0) begin n_fail++; $display("FAIL rst_busy_abandon got req=%0b rdy=%0b exp 0 0", mem_req, dc_ready); end
    n_cmp++; if (dc_rdata !== {LW{1'b0}}) begin n_fail++; $display("FAIL rst_busy_rdata got %0h exp 0", dc_rdata); end
    rst = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1 || dc_ready !== 1'b0 || mem_addr !== 32'h0000_0400) begin n_fail++; $display("FAIL rst_busy_regrant got req=%0b rdy=%0b addr=%0h exp 1 0 400", mem_req, dc_ready, mem_addr); end
    mem_ready = 1'b1; mem_rdata = {16{8'h77}};
    @(negedge clk);
    n_cmp++; if (dc_ready !== 1'b1 || dc_rdata !== {16{8'h77}}) begin n_fail++; $display("FAIL rst_busy_complete got rdy=%0b data=%0h exp 1 77..77", dc_ready, dc_rdata); end
    dc_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Randomized traffic against a transaction-level model.
  task automatic test_random(input int cycles);
    int            streak;
    int            wait_cnt;
    bit            open, resp_due, resp_now, prev_idle, own_d, exp_we, exp_req;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata, exp_line, ic_model, dc_model;
    bit            s_ic, s_dc, s_we;
    logic [AW-1:0] s_ia, s_da;
    logic [LW-1:0] s_wd;
    do_reset();
    streak = 0; wait_cnt = 0; open = 0; resp_due = 0; prev_idle = 1; own_d = 0; exp_we = 0;
    exp_addr = '0; exp_wdata = '0; exp_line = '0; ic_model = '0; dc_model = '0;
    s_ic = 0; s_dc = 0; s_we = 0; s_ia = '0; s_da = '0; s_wd = '0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      resp_now = resp_due;
      resp_due = 0;
      if (resp_now) begin
        exp_req = 0;
        if (!exp_we) begin
          if (own_d) dc_model = exp_line; else ic_model = exp_line;
        end
      end else if (open) begin
        exp_req = 1;
      end else if (prev_idle && (s_ic || s_dc)) begin
        own_d     = s_dc && !(s_ic && streak == 2);
        streak    = own_d ? ((streak == 2) ? 2 : streak + 1) : 0;
        exp_addr  = (own_d ? s_da : s_ia) & ~32'h0000_000F;
        exp_we    = own_d ? s_we : 1'b0;
        exp_wdata = s_wd;
        open      = 1;
        exp_req   = 1;
        wait_cnt  = $urandom_range(0, 3);
      end else begin
        exp_req = 0;
      end
      n_cmp++; if (mem_req !== exp_req) begin n_fail++; $display("FAIL rnd_mem_req cyc%0d got %0b exp %0b", c, mem_req, exp_req); end
      n_cmp++; if (ic_ready !== (resp_now && !own_d)) begin n_fail++; $display("FAIL rnd_ic_ready cyc%0d got %0b exp %0b", c, ic_ready, resp_now && !own_d); end
      n_cmp++; if (dc_ready !== (resp_now && own_d)) begin n_fail++; $display("FAIL rnd_dc_ready cyc%0d got %0b exp %0b", c, dc_ready, resp_now && own_d); end
      n_cmp++; if (ic_rdata !== ic_model) begin n_fail++; $display("FAIL rnd_ic_rdata cyc%0d got %0h exp %0h", c, ic_rdata, ic_model); end
      n_cmp++; if (dc_rdata !== dc_model) begin n_fail++; $display("FAIL rnd_dc_rdata cyc%0d got %0h exp %0h", c, dc_rdata, dc_model); end
      if (exp_req) begin
        n_cmp++; if (mem_addr !== exp_addr || mem_we !== exp_we) begin n_fail++; $display("FAIL rnd_mem_cmd cyc%0d got addr=%0h we=%0b exp addr=%0h we=%0b", c, mem_addr, mem_we, exp_addr, exp_we); end
        if (exp_we) begin
          n_cmp++; if (mem_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_mem_wdata cyc%0d got %0h exp %0h", c, mem_wdata, exp_wdata); end
        end
      end
      prev_idle = !exp_req && !resp_now;

      // memory side
      if (exp_req) begin
        if (wait_cnt == 0) begin
          exp_line = rand_line(); mem_rdata = exp_line; mem_ready = 1'b1;
          open = 0; resp_due = 1;
        end else begin
          wait_cnt--; mem_ready = 1'b0; mem_rdata = rand_line();
        end
        // the owner scribbles its inputs while its transaction is in flight
        if ($urandom_range(0, 1) == 0) begin
          if (own_d) begin dc_addr = $urandom(); dc_we = $urandom_range(0, 1); dc_wdata = rand_line(); end
          else       begin ic_addr = $urandom(); dc_we = $urandom_range(0, 1); end
        end
      end else begin
        mem_ready = ($urandom_range(0, 3) == 0); mem_rdata = rand_line();
      end

      // requester side
      if (resp_now && $urandom_range(0, 1) == 0) begin
        if (own_d) dc_req = 1'b0; else ic_req = 1'b0;
      end
      if (!ic_req && $urandom_range(0, 2) == 0) begin
        ic_req = 1'b1; ic_addr = $urandom();
      end
      if (!dc_req && $urandom_range(0, 2) == 0) begin
        dc_req = 1'b1; dc_addr = $urandom(); dc_we = $urandom_range(0, 1); dc_wdata = rand_line();
      end
      s_ic = ic_req; s_dc = dc_req; s_we = dc_we; s_ia = ic_addr; s_da = dc_addr; s_wd = dc_wdata;
    end
    ic_req = 1'b0; dc_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
    dc_addr = '0; dc_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    test_reset();
    test_ic_fill();
    test_dc_writeback();
    test_back_to_back();
    test_idle_ready();
    test_reset_busy();
    test_random(3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, byte-address width (equals WORD_SIZE).
REQ-002 SHALL have parameter LINE_BITS, default 128, cache-line transfer width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ic_req  input  1  I-cache line-fill request, held until ic_ready.
REQ-006 SHALL have port ic_addr  input  ADDR_BITS  I-cache fill address.
REQ-007 SHALL have port ic_ready  output  1  one-cycle pulse: fill complete.
REQ-008 SHALL have port ic_rdata  output  LINE_BITS  fill line, valid while ic_ready=1.
REQ-009 SHALL have port dc_req  input  1  D-cache request (fill or writeback), held until dc_ready.
REQ-010 SHALL have port dc_we  input  1  1 = line writeback, 0 = line fill.
REQ-011 SHALL have port dc_addr  input  ADDR_BITS  D-cache address.
REQ-012 SHALL have port dc_wdata  input  LINE_BITS  writeback line.
REQ-013 SHALL have port dc_ready  output  1  one-cycle pulse: D transaction complete.
REQ-014 SHALL have port dc_rdata  output  LINE_BITS  fill line, valid while dc_ready=1 and dc_we was 0.
REQ-015 SHALL have port mem_req  output  1  main-memory request, held until mem_ready.
REQ-016 SHALL have port mem_we  output  1  main-memory write enable.
REQ-017 SHALL have port mem_addr  output  ADDR_BITS  line-aligned memory address.
REQ-018 SHALL have port mem_wdata  output  LINE_BITS  write line.
REQ-019 SHALL have port mem_rdata  input  LINE_BITS  read line, valid with mem_ready.
REQ-020 SHALL have port mem_ready  input  1  memory completion, sampled only while mem_req=1.

Function
REQ-021 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-022 IDLE: if any request pending, SHALL latch owner, we, addr, wdata at the edge and enter BUSY; otherwise stay IDLE.
REQ-023 Arbitration: dc wins over ic, except when ic_req=1 and dc_streak=2, in which case ic wins.
REQ-024 dc_streak (2-bit, saturating at 2) SHALL increment on each D grant, clear on each I grant, and hold when idle.
REQ-025 I-side grants SHALL always have mem_we=0 and SHALL ignore dc_we.
REQ-026 mem_addr SHALL be the latched address with its low log2(LINE_BITS/8) bits forced to 0.
REQ-027 BUSY: mem_req=1, and mem_we/mem_addr/mem_wdata SHALL remain stable from the latched registers until mem_ready.
REQ-028 BUSY with mem_ready=1: SHALL capture mem_rdata into the owner's rdata register (reads only) and enter RESP.
REQ-029 RESP: SHALL pulse the owner's ready for exactly one cycle, hold mem_req=0, and return to IDLE.
REQ-030 Minimum latency: request seen in cycle 0, mem_req=1 in cycle 1; with mem_ready=1 in cycle 1, ready pulses in cycle 2.
REQ-031 Requester inputs SHALL be ignored outside IDLE, so changes during BUSY/RESP have no effect.
REQ-032 mem_ready while mem_req=0 SHALL be ignored.
REQ-033 ic_rdata/dc_rdata SHALL hold their last captured value; a D writeback SHALL NOT alter dc_rdata.
REQ-034 A requester keeping req high through RESP SHALL be re-arbitrated in the following IDLE cycle as a new request.
REQ-035 ic_ready and dc_ready SHALL never be high in the same cycle.

Reset
REQ-036 rst=1 at an edge SHALL force IDLE, dc_streak=0, all latched registers and rdata registers to 0, and mem_req, mem_we, ic_ready, dc_ready to 0.
REQ-037 Reset in BUSY or RESP SHALL abandon the transaction: no ready pulse, and mem_req=0 from the cycle after the reset edge.
REQ-038 While rst=1, requests SHALL NOT be granted.

Verification
REQ-039 Scenario: ic_req with ic_addr=0x0000_1004, memory returns 0xA5..A5 after 3 BUSY cycles -> mem_addr=0x0000_1000, mem_we=0, ic_ready pulses once, ic_rdata=0xA5..A5.
REQ-040 Scenario: dc_req with we=1, addr=0x200, wdata=0x1234; mem_ready in first BUSY cycle -> mem_we=1, mem_wdata=0x1234, dc_ready pulses in cycle 2, dc_rdata unchanged.
REQ-041 Scenario: ic_req and dc_req held high continuously -> grant order D, D, I, D, D, I.
REQ-042 Scenario: mem_ready=1 pulses while idle, then a request is issued -> no spurious ready; the request completes normally.
REQ-043 Scenario: rst asserted during the 2nd BUSY cycle of a D fill -> no dc_ready, mem_req=0 next cycle, FSM IDLE, and the next grant works.
REQ-044 Scenario: ic_addr changed mid-BUSY -> mem_addr stays at the latched value until completion.
